// File: rtl/limn2600_bus_arbiter.sv
// Two-master round-robin arbiter for the Limn2600 SRAM bus; one slave access per grant.
// Optional BUSY watchdog abort enabled by defining LIMN2600_ARB_TIMEOUT_EN.
module limn2600_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cs,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rdy,
  output logic          m0_err,
  input  logic          m1_cs,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rdy,
  output logic          m1_err,
  output logic          s_cs,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rdy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          s_cs_q, s_cs_d;
  logic          s_we_q, s_we_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic          busy;
  logic          timeout_hit;
  logic          done;
  logic          winner;

  // A non-positive TIMEOUT has no meaning; this block only elaborates for such a value.
  if (TIMEOUT < 1) begin : g_timeout_out_of_range
  end

  assign busy = (state_q == ST_BUSY);

`ifdef LIMN2600_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] timer_q, timer_d;

  // s_rdy takes priority over an expiring timer in the same cycle.
  assign timeout_hit = busy && !s_rdy && (timer_q == TW'(TIMEOUT));

  always_comb begin
    timer_d = timer_q;
    if (!busy) begin
      timer_d = '0;
    end else if (!s_rdy && !timeout_hit) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = busy && (s_rdy || timeout_hit);

  // Under contention the master that did not win last time goes next.
  always_comb begin
    if (m0_cs && m1_cs) begin
      winner = ~last_q;
    end else begin
      winner = m1_cs;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_cs_d    = s_cs_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cs || m1_cs) begin
          grant_d   = winner;
          s_cs_d    = 1'b1;
          s_we_d    = winner ? m1_we    : m0_we;
          s_addr_d  = winner ? m1_addr  : m0_addr;
          s_wdata_d = winner ? m1_wdata : m0_wdata;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          s_cs_d  = 1'b0;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      s_cs_q    <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      s_cs_q    <= s_cs_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign s_cs    = s_cs_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

  // Replies reach only the granted master; an access cut short by reset never completes.
  assign m0_rdy   = done && !grant_q && !rst;
  assign m1_rdy   = done &&  grant_q && !rst;
  assign m0_err   = timeout_hit && !grant_q && !rst;
  assign m1_err   = timeout_hit &&  grant_q && !rst;
  assign m0_rdata = (busy && s_rdy && !grant_q && !rst) ? s_rdata : '0;
  assign m1_rdata = (busy && s_rdy &&  grant_q && !rst) ? s_rdata : '0;

endmodule
